// File: rtl/spec_acc_ctrl.sv
// Sequencer for the Doppler-spectrum accumulation path: frame/range-bin counting, drain, readout.
// Optional watchdog enabled by defining SPEC_ACC_CTRL_TIMEOUT_EN.
module spec_acc_ctrl #(
    parameter int IDX_W    = 10,
    parameter int RB_W     = 5,
    parameter int NUM_RB   = 16,
    parameter int NUM_ACC  = 8,
    parameter int ACC_LAT  = 4,
    parameter int READ_LAT = 2
`ifdef SPEC_ACC_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_fft_valid,
    input  logic [IDX_W-1:0] i_fft_xk_index,
    input  logic             i_out_ready,
    output logic             o_acc_valid,
    output logic [IDX_W-1:0] o_acc_index,
    output logic [RB_W-1:0]  o_range_bin_cnt,
    output logic [7:0]       o_frame_cnt,
    output logic             o_acc_first,
    output logic             o_rd_en,
    output logic [13:0]      o_rd_addr,
    output logic             o_out_valid,
    output logic             o_out_last,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err_seq,
    output logic             o_err_timeout
);

    typedef enum logic [2:0] {StIdle, StAccum, StDrain, StReadout, StFlush, StDone} state_e;

    localparam logic [IDX_W-1:0] IDX_MAX    = {IDX_W{1'b1}};
    localparam logic [13:0]      LAST_ADDR  = 14'(NUM_RB * (2 ** IDX_W) - 1);
    localparam logic [RB_W-1:0]  RB_ONE     = RB_W'(1);
    localparam logic [RB_W-1:0]  RB_LAST    = RB_W'(NUM_RB);
    localparam logic [7:0]       FRAME_LAST = 8'(NUM_ACC - 1);
    localparam logic [15:0]      DRAIN_LAST = 16'(ACC_LAT);
    localparam logic [15:0]      FLUSH_LAST = 16'(READ_LAT - 1);

    state_e              r_state;
    logic [IDX_W-1:0]    r_exp_idx;
    logic                r_acc_valid;
    logic [IDX_W-1:0]    r_acc_index;
    logic [RB_W-1:0]     r_range_bin_cnt;
    logic [7:0]          r_frame_cnt;
    logic                r_acc_first;
    logic [15:0]         r_wait_cnt;
    logic [13:0]         r_rd_addr;
    logic [READ_LAT-1:0] r_vld_pipe;
    logic [READ_LAT-1:0] r_last_pipe;
    logic                r_done;
    logic                r_err_seq;

    logic w_rd_en;
    logic w_rd_final;
    logic w_blk_end;
    logic w_timeout;

`ifdef SPEC_ACC_CTRL_TIMEOUT_EN
    logic [31:0] r_wd_cnt;
    logic        r_err_timeout;
    assign w_timeout = (r_state == StAccum) && !i_fft_valid &&
                       (r_wd_cnt == 32'(TIMEOUT_CYC - 1));
    assign o_err_timeout = r_err_timeout;
`else
    assign w_timeout     = 1'b0;
    assign o_err_timeout = 1'b0;
`endif

    assign w_rd_en    = (r_state == StReadout) && i_out_ready;
    assign w_rd_final = w_rd_en && (r_rd_addr == LAST_ADDR);
    // Counters advance as the block's last sample leaves the acc_valid register.
    assign w_blk_end  = (r_state == StAccum) && r_acc_valid && (r_acc_index == IDX_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= StIdle;
            r_exp_idx       <= '0;
            r_acc_valid     <= 1'b0;
            r_acc_index     <= '0;
            r_range_bin_cnt <= RB_ONE;
            r_frame_cnt     <= '0;
            r_acc_first     <= 1'b0;
            r_wait_cnt      <= '0;
            r_rd_addr       <= '0;
            r_vld_pipe      <= '0;
            r_last_pipe     <= '0;
            r_done          <= 1'b0;
            r_err_seq       <= 1'b0;
`ifdef SPEC_ACC_CTRL_TIMEOUT_EN
            r_wd_cnt        <= '0;
            r_err_timeout   <= 1'b0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_acc_valid <= 1'b0;
            r_vld_pipe  <= (r_vld_pipe << 1) | READ_LAT'(w_rd_en);
            r_last_pipe <= (r_last_pipe << 1) | READ_LAT'(w_rd_final);
            if (i_abort || w_timeout) begin
                r_state         <= StIdle;
                r_exp_idx       <= '0;
                r_acc_index     <= '0;
                r_range_bin_cnt <= RB_ONE;
                r_frame_cnt     <= '0;
                r_acc_first     <= 1'b0;
                r_wait_cnt      <= '0;
                r_rd_addr       <= '0;
                r_vld_pipe      <= '0;
                r_last_pipe     <= '0;
                r_done          <= !i_abort;
`ifdef SPEC_ACC_CTRL_TIMEOUT_EN
                r_wd_cnt        <= '0;
                if (w_timeout) r_err_timeout <= 1'b1;
`endif
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (i_start) begin
                            r_state         <= StAccum;
                            r_err_seq       <= 1'b0;
                            r_range_bin_cnt <= RB_ONE;
                            r_frame_cnt     <= '0;
                            r_acc_first     <= 1'b1;
                            r_exp_idx       <= '0;
`ifdef SPEC_ACC_CTRL_TIMEOUT_EN
                            r_err_timeout   <= 1'b0;
                            r_wd_cnt        <= '0;
`endif
                        end
                    end
                    StAccum: begin
                        if (i_fft_valid) begin
                            r_acc_valid <= 1'b1;
                            r_acc_index <= i_fft_xk_index;
                            r_exp_idx   <= i_fft_xk_index + IDX_W'(1);
                            if (i_fft_xk_index != r_exp_idx) r_err_seq <= 1'b1;
                        end
`ifdef SPEC_ACC_CTRL_TIMEOUT_EN
                        r_wd_cnt <= i_fft_valid ? '0 : r_wd_cnt + 32'd1;
`endif
                        if (w_blk_end) begin
                            if (r_range_bin_cnt < RB_LAST) begin
                                r_range_bin_cnt <= r_range_bin_cnt + RB_ONE;
                            end else begin
                                r_range_bin_cnt <= RB_ONE;
                                r_frame_cnt     <= r_frame_cnt + 8'd1;
                                r_acc_first     <= 1'b0;
                                if (r_frame_cnt == FRAME_LAST) begin
                                    r_state    <= StDrain;
                                    r_wait_cnt <= '0;
                                end
                            end
                        end
                    end
                    StDrain: begin
                        if (i_fft_valid) r_err_seq <= 1'b1;
                        if (r_wait_cnt == DRAIN_LAST) begin
                            r_state    <= StReadout;
                            r_wait_cnt <= '0;
                            r_rd_addr  <= '0;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 16'd1;
                        end
                    end
                    StReadout: begin
                        if (w_rd_final) begin
                            r_state    <= StFlush;
                            r_wait_cnt <= '0;
                        end else if (w_rd_en) begin
                            r_rd_addr <= r_rd_addr + 14'd1;
                        end
                    end
                    StFlush: begin
                        if (r_wait_cnt == FLUSH_LAST) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 16'd1;
                        end
                    end
                    StDone:  r_state <= StIdle;
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_acc_valid     = r_acc_valid;
    assign o_acc_index     = r_acc_index;
    assign o_range_bin_cnt = r_range_bin_cnt;
    assign o_frame_cnt     = r_frame_cnt;
    assign o_acc_first     = r_acc_first;
    assign o_rd_en         = w_rd_en;
    assign o_rd_addr       = r_rd_addr;
    assign o_out_valid     = r_vld_pipe[READ_LAT-1];
    assign o_out_last      = r_last_pipe[READ_LAT-1];
    assign o_busy          = (r_state != StIdle);
    assign o_done          = r_done;
    assign o_err_seq       = r_err_seq;

endmodule

// File: tb/tb_spec_acc_ctrl.sv
// Scoreboard bench for spec_acc_ctrl: directed accumulation, readout, abort and reset sequences.
// Runs the watchdog scenario when SPEC_ACC_CTRL_TIMEOUT_EN is defined.
module tb_spec_acc_ctrl;
    localparam int IDX_W    = 10;
    localparam int RB_W     = 5;
    localparam int NUM_RB   = 2;
    localparam int NUM_ACC  = 2;
    localparam int ACC_LAT  = 4;
    localparam int READ_LAT = 2;
    localparam int NPTS     = 1 << IDX_W;
    localparam int NBEATS   = NUM_RB * NPTS;
`ifdef SPEC_ACC_CTRL_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 16;
`endif

    logic             clk = 1'b0;
    logic             rst_n, start, abort, fft_valid, out_ready;
    logic [IDX_W-1:0] fft_idx;
    logic             acc_valid, acc_first, rd_en, out_valid, out_last;
    logic             busy, done, err_seq, err_timeout;
    logic [IDX_W-1:0] acc_index;
    logic [RB_W-1:0]  range_bin_cnt;
    logic [7:0]       frame_cnt;
    logic [13:0]      rd_addr;

    spec_acc_ctrl #(
        .IDX_W(IDX_W), .RB_W(RB_W), .NUM_RB(NUM_RB), .NUM_ACC(NUM_ACC),
        .ACC_LAT(ACC_LAT), .READ_LAT(READ_LAT)
`ifdef SPEC_ACC_CTRL_TIMEOUT_EN
        , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_fft_valid(fft_valid), .i_fft_xk_index(fft_idx), .i_out_ready(out_ready),
        .o_acc_valid(acc_valid), .o_acc_index(acc_index), .o_range_bin_cnt(range_bin_cnt),
        .o_frame_cnt(frame_cnt), .o_acc_first(acc_first), .o_rd_en(rd_en), .o_rd_addr(rd_addr),
        .o_out_valid(out_valid), .o_out_last(out_last), .o_busy(busy), .o_done(done),
        .o_err_seq(err_seq), .o_err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        logic [IDX_W-1:0] idx;
        logic [RB_W-1:0]  rb;
        logic [7:0]       frame;
        logic             first;
    } acc_exp_t;

    typedef struct {
        int          cyc;
        logic [13:0] addr;
        logic        last;
    } out_exp_t;

    acc_exp_t acc_q[$];
    out_exp_t out_q[$];

    int n_cmp = 0, n_fail = 0, cyc = 0;
    int m_rb, m_frame, m_addr, rd_cnt, out_cnt, last_cnt, done_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        acc_exp_t ae;
        out_exp_t oe;
        while (acc_q.size() > 0 && acc_q[0].cyc + 1 < cyc) begin
            check("acc_valid_missing", 32'(acc_q[0].cyc + 1), 32'(cyc));
            void'(acc_q.pop_front());
        end
        while (out_q.size() > 0 && out_q[0].cyc < cyc) begin
            check("out_valid_missing", 32'(out_q[0].cyc), 32'(cyc));
            void'(out_q.pop_front());
        end
        if (acc_valid) begin
            if (acc_q.size() == 0) begin
                check("acc_valid_unexpected", 32'(acc_valid), 32'(0));
            end else begin
                ae = acc_q.pop_front();
                check("acc_latency", 32'(cyc), 32'(ae.cyc + 1));
                check("acc_index", 32'(acc_index), 32'(ae.idx));
                check("range_bin_cnt", 32'(range_bin_cnt), 32'(ae.rb));
                check("frame_cnt", 32'(frame_cnt), 32'(ae.frame));
                check("acc_first", 32'(acc_first), 32'(ae.first));
            end
        end
        if (rd_en) begin
            check("rd_en_needs_ready", 32'(out_ready), 32'(1));
            check("rd_addr", 32'(rd_addr), 32'(m_addr));
            oe.cyc  = cyc + READ_LAT;
            oe.addr = 14'(m_addr);
            oe.last = (m_addr == NBEATS - 1);
            out_q.push_back(oe);
            m_addr++;
            rd_cnt++;
        end
        if (out_valid) begin
            if (out_q.size() == 0) begin
                check("out_valid_unexpected", 32'(out_valid), 32'(0));
            end else begin
                oe = out_q.pop_front();
                check("out_latency", 32'(cyc), 32'(oe.cyc));
                check("out_last", 32'(out_last), 32'(oe.last));
                out_cnt++;
                if (out_last) last_cnt++;
            end
        end else if (out_last) begin
            check("out_last_stray", 32'(out_last), 32'(0));
        end
        if (done) done_cnt++;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input int idx);
        acc_exp_t e;
        fft_valid = 1'b1;
        fft_idx   = IDX_W'(idx);
        e.cyc   = cyc;
        e.idx   = IDX_W'(idx);
        e.rb    = RB_W'(m_rb);
        e.frame = 8'(m_frame);
        e.first = (m_frame == 0);
        acc_q.push_back(e);
        if (idx == NPTS - 1) begin
            if (m_rb < NUM_RB) m_rb++;
            else begin
                m_rb = 1;
                m_frame++;
            end
        end
        tick();
        fft_valid = 1'b0;
    endtask

    task automatic do_start();
        m_rb = 1; m_frame = 0; m_addr = 0;
        rd_cnt = 0; out_cnt = 0; last_cnt = 0; done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_accum(input bit skip);
        for (int b = 0; b < NUM_RB * NUM_ACC; b++) begin
            for (int i = 0; i < NPTS; i++) begin
                if (skip && b == 0 && i == 5) continue;
                if (skip && b == 0 && i == 6) check("err_seq_before_6", 32'(err_seq), 32'(0));
                send(i);
                if (skip && b == 0 && i == 6) check("err_seq_after_6", 32'(err_seq), 32'(1));
            end
        end
    endtask

    task automatic run_readout(input bit gapped);
        int  k = 0;
        bit  got_done = 1'b0;
        while (!got_done && k < 20000) begin
            out_ready = !gapped || (k % 3 == 0);
            if (gapped && k == 50) start = 1'b1;
            tick();
            start = 1'b0;
            if (done_cnt > 0) got_done = 1'b1;
            k++;
        end
        out_ready = 1'b0;
        check("readout_done", 32'(done_cnt), 32'(1));
        check("rd_beats", 32'(rd_cnt), 32'(NBEATS));
        check("out_beats", 32'(out_cnt), 32'(NBEATS));
        check("out_last_count", 32'(last_cnt), 32'(1));
        check("out_q_drained", 32'(out_q.size()), 32'(0));
        tick();
        tick();
        check("done_once", 32'(done_cnt), 32'(1));
        check("busy_after_done", 32'(busy), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; fft_valid = 1'b0; out_ready = 1'b0;
        fft_idx = '0;
        m_rb = 1; m_frame = 0; m_addr = 0;
        rd_cnt = 0; out_cnt = 0; last_cnt = 0; done_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc_valid", 32'(acc_valid), 32'(0));
        check("rst_range_bin", 32'(range_bin_cnt), 32'(1));
        check("rst_frame", 32'(frame_cnt), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_rd_addr", 32'(rd_addr), 32'(0));
        check("rst_errs", 32'({err_seq, err_timeout, done, acc_first}), 32'(0));
        rst_n = 1'b1;
        tick();

        // Clean accumulation and full-speed readout.
        do_start();
        check("busy_after_start", 32'(busy), 32'(1));
        run_accum(1'b0);
        check("err_seq_clean", 32'(err_seq), 32'(0));
        run_readout(1'b0);

        // Index 5 skipped in frame 0.
        do_start();
        check("err_seq_cleared_on_start", 32'(err_seq), 32'(0));
        run_accum(1'b1);
        run_readout(1'b0);
        check("err_seq_sticky", 32'(err_seq), 32'(1));

        // Back-pressured readout, stray start while busy.
        do_start();
        run_accum(1'b0);
        run_readout(1'b1);

        // Abort in range bin 2 with a sticky error pending.
        do_start();
        for (int i = 0; i < NPTS; i++) if (i != 5) send(i);
        for (int i = 0; i < 100; i++) send(i);
        check("rb_before_abort", 32'(range_bin_cnt), 32'(m_rb));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_range_bin", 32'(range_bin_cnt), 32'(1));
        check("abort_frame", 32'(frame_cnt), 32'(0));
        check("abort_err_kept", 32'(err_seq), 32'(1));
        check("abort_acc_q", 32'(acc_q.size()), 32'(0));
        repeat (10) tick();
        check("abort_no_done", 32'(done_cnt), 32'(0));
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_same_cycle", 32'(busy), 32'(0));
        do_start();
        run_accum(1'b0);
        run_readout(1'b0);
        check("rerun_err_seq", 32'(err_seq), 32'(0));

        // Asynchronous reset in the middle of readout.
        do_start();
        run_accum(1'b0);
        out_ready = 1'b1;
        repeat (100) tick();
        check("readout_in_progress", 32'(busy), 32'(1));
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_acc_valid", 32'(acc_valid), 32'(0));
        check("arst_range_bin", 32'(range_bin_cnt), 32'(1));
        check("arst_rd_en", 32'(rd_en), 32'(0));
        check("arst_rd_addr", 32'(rd_addr), 32'(0));
        check("arst_out_valid", 32'(out_valid), 32'(0));
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_flags", 32'({done, err_seq, err_timeout, acc_first, out_last}), 32'(0));
        acc_q.delete();
        out_q.delete();
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        repeat (10) tick();
        out_ready = 1'b0;
        check("post_rst_out_valid", 32'(out_valid), 32'(0));
        check("post_rst_busy", 32'(busy), 32'(0));

`ifdef SPEC_ACC_CTRL_TIMEOUT_EN
        begin
            int idle = 0;
            do_start();
            for (int i = 0; i < 100; i++) send(i);
            while (done_cnt == 0 && idle < 100) begin
                tick();
                idle++;
            end
            check("timeout_idle_cycles", 32'(idle), 32'(TIMEOUT_CYC + 1));
            check("timeout_flag", 32'(err_timeout), 32'(1));
            tick();
            check("timeout_idle_state", 32'(busy), 32'(0));
            check("timeout_done_once", 32'(done_cnt), 32'(1));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spec_acc_ctrl.md
Name: spec_acc_ctrl

Overview:
- Top-level sequencer for the Doppler-spectrum accumulation path.
- Counts FFT output samples, range bins and accumulation frames, and drives the range-bin counter, valid and index inputs of the accumulator address/write-enable generator.
- Once all frames are accumulated, it sweeps the accumulation DPRAM read port to stream results to the detector. It then pulses done.

Parameters:
- IDX_W, 10: FFT index width (1024 points).
- RB_W, 5: range-bin counter width.
- NUM_RB, 16: range bins per frame; NUM_RB*2^IDX_W must be <= 2^14.
- NUM_ACC, 8: frames accumulated per cycle (>=1).
- ACC_LAT, 4: accumulator write pipeline depth to drain before readout.
- READ_LAT, 2: DPRAM read latency, rd_en to data.
- TIMEOUT_CYC, 4096: watchdog limit (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begins an accumulation cycle
- abort  in  1  synchronous abort, returns to IDLE
- fft_valid  in  1  FFT output sample valid
- fft_xk_index  in  IDX_W  FFT output index of the current sample
- out_ready  in  1  detector can accept readout beats
- acc_valid  out  1  registered copy of fft_valid gated by ACCUM state
- acc_index  out  IDX_W  registered copy of fft_xk_index
- range_bin_cnt  out  RB_W  current range bin, 1-based
- frame_cnt  out  8  current frame, 0-based
- acc_first  out  1  high during frame 0 (accumulator overwrites instead of adding)
- rd_en  out  1  DPRAM read strobe
- rd_addr  out  14  DPRAM read address {bin-1, index}
- out_valid  out  1  readout data valid (rd_en delayed READ_LAT)
- out_last  out  1  with final out_valid beat
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of readout
- err_seq  out  1  sticky: sample index not as expected
- err_timeout  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset values: all outputs 0, except range_bin_cnt = 1. State is IDLE, all counters 0.
- States: IDLE, ACCUM, DRAIN, READOUT, FLUSH, DONE.
- IDLE:
  - start goes to ACCUM.
  - On entry to ACCUM: clear err_seq and err_timeout, set range_bin_cnt = 1, frame_cnt = 0, expected index = 0.
  - start while busy is ignored.
- ACCUM:
  - Each fft_valid beat: acc_valid = 1 and acc_index = fft_xk_index, one cycle later.
  - If fft_xk_index != expected, set err_seq and resync expected = fft_xk_index+1. The sample is still forwarded.
  - When the accepted sample has index 2^IDX_W-1, expected wraps to 0.
    - If range_bin_cnt < NUM_RB, range_bin_cnt increments.
    - Otherwise range_bin_cnt = 1 and frame_cnt increments.
    - If that was frame NUM_ACC-1, go to DRAIN.
  - acc_first = (frame_cnt == 0). acc_first, range_bin_cnt and frame_cnt update in the cycle after the last sample, aligned with the acc_valid pipeline.
- DRAIN:
  - Waits ACC_LAT+1 cycles, then goes to READOUT.
  - fft_valid here is ignored and sets err_seq.
- READOUT:
  - Linear address 0 .. NUM_RB*2^IDX_W-1.
  - rd_en = out_ready. Address advances only on rd_en.
  - out_valid = rd_en delayed READ_LAT. Beats in flight are always delivered; the detector absorbs up to READ_LAT beats after dropping out_ready.
  - After the final address is issued, go to FLUSH.
  - out_last accompanies the out_valid of the final address.
- FLUSH: waits READ_LAT cycles, then goes to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- abort, any state: next cycle IDLE, counters cleared, in-flight out_valid pipeline cleared, no done pulse. Sticky errors are retained.
- rst_n low: immediate reset of everything, regardless of state.
- Simultaneous start and abort: abort wins.

Optional Feature:
- Macro: SPEC_ACC_CTRL_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in ACCUM without fft_valid and clears on each valid.
  - Reaching TIMEOUT_CYC sets err_timeout, moves to IDLE as on abort, and pulses done (the system is not left hung).
- Undefined: no counter; ACCUM waits indefinitely; err_timeout tied to 0.

Test Plan:
- NUM_RB=2, NUM_ACC=2, start, 4 full in-order index blocks 0..1023 -> range_bin_cnt sequence 1,2,1,2; acc_first high for the first 2048 samples only; no errors; then 2048 readout beats, rd_addr 0..2047, out_last on beat 2048, done once.
- Index 5 skipped in frame 0 -> err_seq = 1 from the cycle after index 6 arrives; counting continues and the cycle completes with done.
- out_ready toggles 1 cycle on / 2 off during READOUT -> rd_addr advances only on rd_en; out_valid follows rd_en by exactly 2 cycles; 2048 beats total.
- abort mid-ACCUM at range bin 2 -> busy = 0 next cycle, range_bin_cnt = 1, no done; a new start runs normally.
- rst_n low during READOUT -> all outputs 0 and range_bin_cnt = 1 asynchronously; out_valid stays 0 after release.
- With SPEC_ACC_CTRL_TIMEOUT_EN and TIMEOUT_CYC=16, fft_valid stops mid-block -> err_timeout = 1 after 16 idle cycles, done pulses, state is IDLE.
